// File: rtl/result_demux.sv
// result_demux: one-to-four result distributor with a 1-entry valid/ready slot per port.
// Define RESULT_DEMUX_CNT_EN to add per-port accepted-transfer counters cnt_port0..3.
module result_demux #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel_op,
  input  logic [1:0]       in_sel_port,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
`ifdef RESULT_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_port0,
  output logic [CNT_W-1:0] cnt_port1,
  output logic [CNT_W-1:0] cnt_port2,
  output logic [CNT_W-1:0] cnt_port3
`endif
);
  logic [1:0]       dest;
  logic [3:0]       drain;
  logic [3:0]       load;
  logic [WIDTH-1:0] data_q [4];
  assign dest     = in_sel_op ? in_sel_port : {1'b0, in_sel_port[0]};
  assign drain    = out_valid & out_ready;
  assign in_ready = !flush && (!out_valid[dest] || drain[dest]);
  assign load     = (in_valid && in_ready) ? (4'b0001 << dest) : 4'b0000;
  // a drain and a refill of the same slot in one cycle keeps it full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      out_valid <= flush ? 4'b0000 : ((out_valid & ~drain) | load);
      for (int i = 0; i < 4; i++) if (load[i]) data_q[i] <= in_data;
    end
  end
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
`ifdef RESULT_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt [4];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 4; i++) cnt[i] <= '0;
    else for (int i = 0; i < 4; i++) if (load[i]) cnt[i] <= cnt[i] + 1'b1;
  end
  assign cnt_port0 = cnt[0];
  assign cnt_port1 = cnt[1];
  assign cnt_port2 = cnt[2];
  assign cnt_port3 = cnt[3];
`endif
endmodule

// File: tb/tb_result_demux.sv
// tb_result_demux: directed vector table plus hand sequences for async reset, streaming and counters.
module tb_result_demux;
  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = 0;
  logic        in_sel_op = 0;
  logic [1:0]  in_sel_port = 0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 0;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
`ifdef RESULT_DEMUX_CNT_EN
  logic [3:0]  cnt_port0, cnt_port1, cnt_port2, cnt_port3;
`endif
  int total = 0;
  int bad = 0;

  result_demux #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel_op(in_sel_op), .in_sel_port(in_sel_port),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3)
`ifdef RESULT_DEMUX_CNT_EN
    , .cnt_port0(cnt_port0), .cnt_port1(cnt_port1), .cnt_port2(cnt_port2), .cnt_port3(cnt_port3)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        op;
    logic [1:0]  sp;
    logic [3:0]  ordy;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  vld;
    int          p;
    logic [31:0] pd;
  } vec_t;

  vec_t v [20];

  function automatic logic [31:0] port_data(int p);
    return p == 0 ? out_data0 : p == 1 ? out_data1 : p == 2 ? out_data2 : out_data3;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // called at a negedge: drive, check in_ready, clock, check registered state
  task automatic run(vec_t t, string nm);
    flush = t.fl; in_valid = t.iv; in_sel_op = t.op; in_sel_port = t.sp;
    out_ready = t.ordy; in_data = t.d;
    #1 chk({nm, " in_ready"}, 32'(in_ready), 32'(t.rdy));
    @(posedge clk);
    #1 chk({nm, " out_valid"}, 32'(out_valid), 32'(t.vld));
    chk($sformatf("%s out_data%0d", nm, t.p), port_data(t.p), t.pd);
    @(negedge clk);
  endtask

  initial begin
    //        fl iv op sp     ordy     data          rdy vld      p  pdata
    v[0]  = '{0, 1, 0, 2'b11, 4'b1111, 32'hDEADBEEF, 1, 4'b0010, 1, 32'hDEADBEEF};
    v[1]  = '{0, 1, 1, 2'd0,  4'b1111, 32'd1,        1, 4'b0001, 0, 32'd1};
    v[2]  = '{0, 1, 1, 2'd1,  4'b1111, 32'd2,        1, 4'b0010, 1, 32'd2};
    v[3]  = '{0, 1, 1, 2'd2,  4'b1111, 32'd3,        1, 4'b0100, 2, 32'd3};
    v[4]  = '{0, 1, 1, 2'd3,  4'b1111, 32'd4,        1, 4'b1000, 3, 32'd4};
    v[5]  = '{0, 0, 1, 2'd3,  4'b1111, 32'd0,        1, 4'b0000, 3, 32'd4};
    v[6]  = '{0, 1, 1, 2'd2,  4'b0000, 32'hA5A5A5A5, 1, 4'b0100, 2, 32'hA5A5A5A5};
    v[7]  = '{0, 1, 1, 2'd2,  4'b0000, 32'h5A5A5A5A, 0, 4'b0100, 2, 32'hA5A5A5A5};
    v[8]  = '{0, 1, 1, 2'd0,  4'b0000, 32'h11111111, 1, 4'b0101, 0, 32'h11111111};
    v[9]  = '{0, 1, 1, 2'd2,  4'b0100, 32'h5A5A5A5A, 1, 4'b0101, 2, 32'h5A5A5A5A};
    v[10] = '{0, 1, 1, 2'd1,  4'b0000, 32'h22,       1, 4'b0111, 1, 32'h22};
    v[11] = '{0, 1, 1, 2'd3,  4'b0100, 32'h33,       1, 4'b1011, 3, 32'h33};
    v[12] = '{1, 1, 1, 2'd2,  4'b0000, 32'h44,       0, 4'b0000, 2, 32'h5A5A5A5A};
    v[13] = '{0, 1, 0, 2'b10, 4'b0000, 32'h55,       1, 4'b0001, 0, 32'h55};
    v[14] = '{0, 1, 0, 2'b00, 4'b0000, 32'h66,       0, 4'b0001, 0, 32'h55};
    v[15] = '{0, 0, 0, 2'b00, 4'b0001, 32'h0,        1, 4'b0000, 0, 32'h55};
    v[16] = '{0, 1, 1, 2'd0,  4'b0000, 32'hA0,       1, 4'b0001, 0, 32'hA0};
    v[17] = '{0, 1, 1, 2'd1,  4'b0000, 32'hA1,       1, 4'b0011, 1, 32'hA1};
    v[18] = '{0, 1, 1, 2'd2,  4'b0000, 32'hA2,       1, 4'b0111, 2, 32'hA2};
    v[19] = '{0, 1, 1, 2'd3,  4'b0000, 32'hA3,       1, 4'b1111, 3, 32'hA3};
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    for (int p = 0; p < 4; p++) chk($sformatf("reset out_data%0d", p), port_data(p), 32'h0);
    rst = 0;
    #1 chk("reset in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 20; i++) run(v[i], $sformatf("vec%0d", i));
    in_valid = 0; out_ready = 4'b0000;
    #2 rst = 1;
    #1 chk("async rst out_valid", 32'(out_valid), 32'h0);
    for (int p = 0; p < 4; p++) chk($sformatf("async rst out_data%0d", p), port_data(p), 32'h0);
    @(negedge clk);
    rst = 0; in_sel_op = 1; in_sel_port = 2'd3;
    #1 chk("post rst in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    for (int k = 1; k <= 17; k++) run('{0, 1, 1, 2'd3, 4'b1111, 32'(k), 1, 4'b1000, 3, 32'(k)}, $sformatf("stream%0d", k));
`ifdef RESULT_DEMUX_CNT_EN
    chk("cnt_port3 wrap", 32'(cnt_port3), 32'h1);
    chk("cnt_port0", 32'(cnt_port0), 32'h0);
    chk("cnt_port1", 32'(cnt_port1), 32'h0);
    chk("cnt_port2", 32'(cnt_port2), 32'h0);
`endif
    run('{1, 0, 1, 2'd3, 4'b0000, 32'h0, 0, 4'b0000, 3, 32'd17}, "flush");
`ifdef RESULT_DEMUX_CNT_EN
    chk("cnt_port3 after flush", 32'(cnt_port3), 32'h1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
